// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic       PORT_IF    = 1'b0;
    localparam logic       PORT_DM    = 1'b1;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant selection between instruction and data ports.
// Define SRAM_ARB_RR_EN for round-robin priority; default is fixed data-port priority.
module sram_arb_grant
    import sram_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_port
);

    assign grant_valid = if_req | dm_req;

`ifdef SRAM_ARB_RR_EN
    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant_port = PORT_IF;
        if (if_req && dm_req) begin
            grant_port = (last_grant == PORT_DM) ? PORT_IF : PORT_DM;
        end else if (dm_req) begin
            grant_port = PORT_DM;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_port = dm_req ? PORT_DM : PORT_IF;
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between the fetch and data-memory ports.
// Optional round-robin arbitration via SRAM_ARB_RR_EN (see sram_arb_grant).
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    arb_state_t        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic              we_l;
    logic              port_l;
    logic              last_grant;
    logic              grant_valid;
    logic              grant_port;
    logic [ADDR_W-1:0] sel_addr;
    logic              misaligned;

    sram_arb_grant u_grant (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign sel_addr   = (grant_port == PORT_DM) ? dm_addr : if_addr;
    assign misaligned = (sel_addr[1:0] & ALIGN_MASK) != 2'b00;

    // Latched operands drive the SRAM bus directly so they stay stable SETUP..DONE.
    assign sram_addr = addr_l;
    assign sram_din  = wdata_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_l     <= '0;
            wdata_l    <= '0;
            we_l       <= 1'b0;
            port_l     <= PORT_IF;
            last_grant <= PORT_IF;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_err     <= 1'b0;
            dm_err     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            sram_cs    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        addr_l     <= sel_addr;
                        wdata_l    <= (grant_port == PORT_DM) ? dm_wdata : '0;
                        we_l       <= (grant_port == PORT_DM) && dm_we;
                        port_l     <= grant_port;
                        last_grant <= grant_port;
                        // Misaligned requests skip the SRAM entirely and complete with an error.
                        if (misaligned) begin
                            state  <= DONE;
                            if_ack <= (grant_port == PORT_IF);
                            dm_ack <= (grant_port == PORT_DM);
                            if_err <= (grant_port == PORT_IF);
                            dm_err <= (grant_port == PORT_DM);
                        end else begin
                            state   <= SETUP;
                            sram_cs <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    sram_oe <= ~we_l;
                    sram_we <= we_l;
                    cnt     <= 4'(WAIT_CYCLES - 1);
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state   <= DONE;
                        sram_cs <= 1'b0;
                        sram_oe <= 1'b0;
                        sram_we <= 1'b0;
                        if_ack  <= (port_l == PORT_IF);
                        dm_ack  <= (port_l == PORT_DM);
                        if (!we_l && port_l == PORT_IF) begin
                            if_rdata <= sram_dout;
                        end
                        if (!we_l && port_l == PORT_DM) begin
                            dm_rdata <= sram_dout;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    if_err <= 1'b0;
                    dm_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (default fixed-priority build).
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic        if_ack, if_err, dm_ack, dm_err;
    logic [31:0] if_rdata, dm_rdata;
    logic        sram_cs, sram_oe, sram_we;
    logic [31:0] sram_addr, sram_din, sram_dout;

    logic [31:0] mem [0:63];

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Asynchronous SRAM model; reset reloads a known word at 0x10.
    assign sram_dout = (sram_cs && sram_oe) ? mem[sram_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'h0000_0005;
        end else if (sram_cs && sram_we) begin
            mem[sram_addr[7:2]] <= sram_din;
        end
    end

    // Extra instances for the WAIT_CYCLES=1 and 15 latency corners.
    logic        req1, ack1, oe1, cs1, we1;
    logic        req15, ack15, oe15, cs15, we15;
    logic [31:0] rdata1, rdata15;
    logic        unused_err1, unused_dack1, unused_derr1, unused_err15, unused_dack15, unused_derr15;
    logic [31:0] unused_drd1, unused_addr1, unused_din1, unused_drd15, unused_addr15, unused_din15;

    sram_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32), .DATA_W(32)) dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(req1), .if_addr(32'h0000_0040), .if_ack(ack1), .if_rdata(rdata1), .if_err(unused_err1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_ack(unused_dack1), .dm_rdata(unused_drd1), .dm_err(unused_derr1),
        .sram_cs(cs1), .sram_oe(oe1), .sram_we(we1),
        .sram_addr(unused_addr1), .sram_din(unused_din1), .sram_dout(32'h1111_0001)
    );

    sram_port_arbiter #(.WAIT_CYCLES(15), .ADDR_W(32), .DATA_W(32)) dut_w15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(req15), .if_addr(32'h0000_0040), .if_ack(ack15), .if_rdata(rdata15), .if_err(unused_err15),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_ack(unused_dack15), .dm_rdata(unused_drd15), .dm_err(unused_derr15),
        .sram_cs(cs15), .sram_oe(oe15), .sram_we(we15),
        .sram_addr(unused_addr15), .sram_din(unused_din15), .sram_dout(32'h1515_0015)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer on the main instance and reports what was observed.
    task automatic applyStimulus(input logic is_dm, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output int lat, output int cs_w, output int oe_w, output int we_w,
                                 output logic wrong_ack, output logic [31:0] rdata,
                                 output logic err, output logic ack_after);
        if (is_dm) begin
            dm_req = 1'b1; dm_we = wr; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = 0; cs_w = 0; oe_w = 0; we_w = 0; wrong_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            lat++;
            if (sram_cs) cs_w++;
            if (sram_oe) oe_w++;
            if (sram_we) we_w++;
            if (is_dm ? if_ack : dm_ack) wrong_ack = 1'b1;
            if (is_dm ? dm_ack : if_ack) break;
        end
        rdata = is_dm ? dm_rdata : if_rdata;
        err   = is_dm ? dm_err : if_err;
        if_req = 1'b0;
        dm_req = 1'b0;
        nextCycle();
        ack_after = if_ack | dm_ack;
    endtask

    int          lat, cs_w, oe_w, we_w, dm_at, if_at, lat1, lat15, oew1, oew15;
    logic        wrong_ack, err, ack_after, saw_ack;
    logic [31:0] rdata;

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        req1 = 1'b0; req15 = 1'b0;
        repeat (3) nextCycle();

        checkOutput("reset_acks", {30'h0, if_ack, dm_ack}, 32'h0);
        checkOutput("reset_ctrl", {29'h0, sram_cs, sram_oe, sram_we}, 32'h0);
        checkOutput("reset_errs", {30'h0, if_err, dm_err}, 32'h0);
        checkOutput("reset_addr", sram_addr, 32'h0);
        checkOutput("reset_if_rdata", if_rdata, 32'h0);
        checkOutput("reset_dm_rdata", dm_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, lat, cs_w, oe_w, we_w, wrong_ack, rdata, err, ack_after);
        checkOutput("rd_latency", lat, 4);
        checkOutput("rd_cs_width", cs_w, 3);
        checkOutput("rd_oe_width", oe_w, 2);
        checkOutput("rd_if_rdata", rdata, 32'h0000_0005);
        checkOutput("rd_err", {31'h0, err}, 32'h0);
        checkOutput("rd_other_ack", {31'h0, wrong_ack}, 32'h0);
        checkOutput("rd_ack_pulse", {31'h0, ack_after}, 32'h0);
        checkOutput("rd_rdata_held", if_rdata, 32'h0000_0005);

        applyStimulus(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, lat, cs_w, oe_w, we_w, wrong_ack, rdata, err, ack_after);
        checkOutput("wr_latency", lat, 4);
        checkOutput("wr_we_width", we_w, 2);
        checkOutput("wr_oe_width", oe_w, 0);
        checkOutput("wr_rdata_held", rdata, 32'h0);
        checkOutput("wr_mem", mem[8], 32'hDEAD_BEEF);
        checkOutput("wr_other_ack", {31'h0, wrong_ack}, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, lat, cs_w, oe_w, we_w, wrong_ack, rdata, err, ack_after);
        checkOutput("rdback_latency", lat, 4);
        checkOutput("rdback_dm_rdata", rdata, 32'hDEAD_BEEF);

        // Both ports request together: data port first, instruction port five cycles later.
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        dm_at = -1; if_at = -1;
        for (int c = 1; c <= 30 && if_at < 0; c++) begin
            nextCycle();
            if (dm_ack && dm_at < 0) begin dm_at = c; dm_req = 1'b0; end
            if (if_ack && if_at < 0) begin if_at = c; if_req = 1'b0; end
        end
        if_req = 1'b0; dm_req = 1'b0;
        checkOutput("cont_dm_cycle", dm_at, 4);
        checkOutput("cont_if_cycle", if_at, 9);
        checkOutput("cont_if_rdata", if_rdata, 32'h0000_0005);
        checkOutput("cont_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        nextCycle();

        applyStimulus(1'b1, 1'b0, 32'h22, 32'h0, lat, cs_w, oe_w, we_w, wrong_ack, rdata, err, ack_after);
        checkOutput("mis_dm_latency", lat, 1);
        checkOutput("mis_dm_err", {31'h0, err}, 32'h1);
        checkOutput("mis_dm_cs", cs_w, 0);
        checkOutput("mis_dm_ack_pulse", {31'h0, ack_after}, 32'h0);
        checkOutput("mis_dm_err_clear", {31'h0, dm_err}, 32'h0);

        applyStimulus(1'b0, 1'b0, 32'h13, 32'h0, lat, cs_w, oe_w, we_w, wrong_ack, rdata, err, ack_after);
        checkOutput("mis_if_latency", lat, 1);
        checkOutput("mis_if_err", {31'h0, err}, 32'h1);
        checkOutput("mis_if_cs", cs_w, 0);

        // Latency corners on the WAIT_CYCLES=1 and 15 instances.
        req1 = 1'b1; req15 = 1'b1;
        lat1 = -1; lat15 = -1; oew1 = 0; oew15 = 0;
        for (int c = 1; c <= 40 && lat15 < 0; c++) begin
            nextCycle();
            if (lat1 < 0 && oe1) oew1++;
            if (lat15 < 0 && oe15) oew15++;
            if (ack1 && lat1 < 0) begin lat1 = c; req1 = 1'b0; checkOutput("w1_rdata", rdata1, 32'h1111_0001); end
            if (ack15 && lat15 < 0) begin lat15 = c; req15 = 1'b0; checkOutput("w15_rdata", rdata15, 32'h1515_0015); end
        end
        req1 = 1'b0; req15 = 1'b0;
        checkOutput("w1_latency", lat1, 3);
        checkOutput("w1_oe_width", oew1, 1);
        checkOutput("w15_latency", lat15, 17);
        checkOutput("w15_oe_width", oew15, 15);
        nextCycle();

        // Reset while the read is in ACCESS: controls fall at once and no ack follows.
        if_req = 1'b1; if_addr = 32'h10;
        nextCycle();
        nextCycle();
        checkOutput("rst_mid_oe_before", {30'h0, sram_cs, sram_oe}, 32'h3);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ctrl", {29'h0, sram_cs, sram_oe, sram_we}, 32'h0);
        if_req = 1'b0;
        saw_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            if (if_ack || dm_ack) saw_ack = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            if (if_ack || dm_ack || sram_cs) saw_ack = 1'b1;
        end
        checkOutput("rst_mid_no_ack", {31'h0, saw_ack}, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, lat, cs_w, oe_w, we_w, wrong_ack, rdata, err, ack_after);
        checkOutput("rst_after_latency", lat, 4);
        checkOutput("rst_after_rdata", rdata, 32'h0000_0005);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Clocked front-end that shares the single asynchronous `sram` model between the DLX instruction-fetch port and the data-memory (MEM stage) port. The block arbitrates between the two requesters and sequences the SRAM control lines `cs`/`oe`/`we` with an address-setup phase and a programmable number of access cycles. It returns read data with a one-cycle acknowledge pulse and sits between the pipeline stage registers and the `sram` instance.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles `oe`/`we` are held asserted per access; legal range 1..15.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  instruction port request; read only.
- `if_addr`  in  ADDR_W  instruction word address.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ack`=1, held afterwards.
- `if_err`  out  1  misaligned address; qualified by `if_ack`.
- `dm_req`  in  1  data port request.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_ack`  out  1  one-cycle completion pulse.
- `dm_rdata`  out  DATA_W  read word; valid while `dm_ack`=1.
- `dm_err`  out  1  misaligned address; qualified by `dm_ack`.
- `sram_cs`, `sram_oe`, `sram_we`  out  1 each  SRAM controls.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_din`  out  DATA_W  SRAM write data.
- `sram_dout`  in  DATA_W  SRAM read data.

## Operation
FSM states are IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - Samples `if_req`/`dm_req`. With neither asserted, stays in IDLE.
  - On a grant, latches the address, write data, `we` and the granted port id into internal registers.
  - If the latched `addr[1:0]` is not 00, goes directly to DONE with `err`=1. No SRAM access is made: `sram_cs` stays 0.
  - Otherwise goes to SETUP.
- **SETUP**: `sram_cs`=1, `sram_addr`/`sram_din` driven, `oe`=`we`=0. Lasts one cycle.
- **ACCESS**: `sram_cs`=1; `sram_oe`=~we_l or `sram_we`=we_l, for WAIT_CYCLES cycles.
  - The down-counter is loaded with WAIT_CYCLES-1 on entry.
  - The block exits when the counter is 0. On that last cycle, `sram_dout` is captured into the granted port's rdata register (reads only).
- **DONE**
  - All SRAM controls are 0; address and data are held.
  - The granted port's `ack` is 1 for exactly this cycle. The other port's `ack` stays 0.
  - Always returns to IDLE.
- **Arbitration**: the data port has fixed priority when both ports request in the same IDLE cycle. The losing request stays pending.
- **Handshake**
  - A requester holds `req` and its operands stable until it sees `ack`.
  - A requester may re-assert `req` for the next transfer in the cycle after `ack`.
  - Changing operands while a request is pending and unacknowledged is illegal.
- **Write data**: write `rdata` is not updated and the old value is held.
- **Reset values**: all outputs are 0, the FSM is in IDLE, the counter is 0 and the rdata registers are 0.
- **Reset mid-transfer**: any in-flight transfer is dropped with no `ack`, and the SRAM controls drop asynchronously.

## Timing
- With the request sampled in IDLE at cycle N, the SETUP cycle is N+1.
- ACCESS occupies cycles N+2..N+1+WAIT_CYCLES.
- `ack` is asserted at N+2+WAIT_CYCLES, giving latency WAIT_CYCLES+2.
- Back-to-back throughput is one transfer per WAIT_CYCLES+3 cycles.
- A misaligned access acks at N+1.
- `sram_addr` and `sram_din` are stable from SETUP through DONE, so the address is valid one cycle before `oe`/`we` rise and one cycle after they fall.
- All outputs are registered, with no combinational path from `req` to `sram_*`.

## Configuration
- **`SRAM_ARB_RR_EN` defined**: round-robin priority. On a contended IDLE cycle, the port not granted last wins. The last-grant flop resets to "instruction", so the first contended grant goes to the data port.
- **`SRAM_ARB_RR_EN` undefined**: fixed data-port priority. The last-grant flop is absent.

## Structure
- **Package `sram_arb_pkg`**
  - State enum `arb_state_t` {IDLE, SETUP, ACCESS, DONE}.
  - Port id constants `PORT_IF`=0 and `PORT_DM`=1.
  - Alignment mask constant `ALIGN_MASK`=2'b11.
- **Sub-module `sram_arb_grant`**: combinational grant logic (`if_req`, `dm_req`, last_grant → grant_valid, grant_port), instantiated in the top.
  - This is the only place `SRAM_ARB_RR_EN` is tested.
- The FSM, counter and datapath registers live in the top module.

## Test plan
- **Single read, WAIT_CYCLES=2**: preload addr 0x10 = 0x0000_0005; `if_req`@0x10 at cycle 0 → `sram_cs` high cycles 1–3, `sram_oe` high cycles 2–3, `if_ack` pulse at cycle 4 with `if_rdata`=0x0000_0005.
- **Write then read**: `dm_req` write 0xDEAD_BEEF@0x20 → `sram_we` high 2 cycles and `dm_ack`; then `dm_req` read @0x20 → `dm_rdata`=0xDEAD_BEEF.
- **Contention**: both `req` asserted in the same cycle, repeated.
  - Fixed mode: data port served first, then the instruction port 5 cycles later.
  - With `SRAM_ARB_RR_EN`: grants alternate DM, IF, DM, IF.
- **Misaligned address**: `dm_addr`=0x22 → `dm_ack` and `dm_err`=1 one cycle later, with `sram_cs` never asserted.
- **Reset mid-ACCESS**: assert `rst_n`=0 during ACCESS → `sram_cs`/`sram_oe` drop immediately and no `ack`; after release, a fresh read completes normally.
- **WAIT_CYCLES=1 and 15**: measured read latency is 3 and 17 cycles respectively, with `oe` pulse width equal to WAIT_CYCLES.
